// File: rtl/riscv_multi_ctrl.sv
//==============================================================================
// Module      : riscv_multi_ctrl
// Description : Multi-cycle RV32I subset control unit (Moore FSM plus ALU and
//               immediate decode) for lw/sw/R-type/I-type/beq/jal.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module riscv_multi_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_we,
  output logic       adr_src,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] res_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       retire,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b101;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  state_t     r_state;
  state_t     w_next;
  logic       r_err;

  logic       w_pc_we;
  logic       w_adr_src;
  logic       w_mem_we;
  logic       w_ir_we;
  logic       w_reg_we;
  logic [1:0] w_res_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_ctrl;
  logic       w_retire;
  logic [2:0] w_alu_dec;
  logic       w_alu_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= state_t'(RESET_STATE);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ERROR)
        r_err <= 1'b1;
    end
  end

  // ALU decode; an unsupported funct3 diverts EXECR/EXECI to ERROR.
  always_comb begin
    w_alu_dec = c_alu_add;
    w_alu_ok  = 1'b1;
    case (funct3)
      3'b000:  w_alu_dec = (op[5] && funct7b5) ? c_alu_sub : c_alu_add;
      3'b010:  w_alu_dec = c_alu_slt;
      3'b110:  w_alu_dec = c_alu_or;
      3'b111:  w_alu_dec = c_alu_and;
      default: w_alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_pc_we     = 1'b0;
    w_adr_src   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_we     = 1'b0;
    w_reg_we    = 1'b0;
    w_res_src   = 2'b00;
    w_alu_src_a = 2'b00;
    w_alu_src_b = 2'b00;
    w_alu_ctrl  = c_alu_add;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next      = S_DECODE;
        w_ir_we     = 1'b1;
        w_alu_src_b = 2'b10;
        w_res_src   = 2'b10;
        w_pc_we     = 1'b1;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (op)
          c_op_load, c_op_store: w_next = S_MEMADR;
          c_op_rtype:            w_next = S_EXECR;
          c_op_itype:            w_next = S_EXECI;
          c_op_branch:           w_next = S_BEQ;
          c_op_jal:              w_next = S_JAL;
          default:               w_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        w_next      = op[5] ? S_MEMWRITE : S_MEMREAD;
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_next    = S_MEMWB;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_next    = S_FETCH;
        w_res_src = 2'b01;
        w_reg_we  = 1'b1;
        w_retire  = 1'b1;
      end
      S_MEMWRITE: begin
        w_next    = S_FETCH;
        w_adr_src = 1'b1;
        w_mem_we  = 1'b1;
        w_retire  = 1'b1;
      end
      S_EXECR: begin
        w_next      = w_alu_ok ? S_ALUWB : S_ERROR;
        w_alu_src_a = 2'b10;
        w_alu_ctrl  = w_alu_dec;
      end
      S_EXECI: begin
        w_next      = w_alu_ok ? S_ALUWB : S_ERROR;
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_ctrl  = w_alu_dec;
      end
      S_ALUWB: begin
        w_next   = S_FETCH;
        w_reg_we = 1'b1;
        w_retire = 1'b1;
      end
      S_BEQ: begin
        w_next      = S_FETCH;
        w_alu_src_a = 2'b10;
        w_alu_ctrl  = c_alu_sub;
        w_pc_we     = zero;
        w_retire    = 1'b1;
      end
      S_JAL: begin
        w_next      = S_ALUWB;
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_we     = 1'b1;
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_ERROR;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      c_op_store:  imm_src = 2'b01;
      c_op_branch: imm_src = 2'b10;
      c_op_jal:    imm_src = 2'b11;
      default:     imm_src = 2'b00;
    endcase
  end

  // Enables are gated by rst so nothing pulses while reset is held.
  assign pc_we     = w_pc_we  & ~rst;
  assign ir_we     = w_ir_we  & ~rst;
  assign mem_we    = w_mem_we & ~rst;
  assign reg_we    = w_reg_we & ~rst;
  assign retire    = w_retire & ~rst;
  assign adr_src   = w_adr_src;
  assign res_src   = w_res_src;
  assign alu_src_a = w_alu_src_a;
  assign alu_src_b = w_alu_src_b;
  assign alu_ctrl  = w_alu_ctrl;
  assign err       = r_err;
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_riscv_multi_ctrl.sv
//==============================================================================
// Module      : tb_riscv_multi_ctrl
// Description : Table-driven bench for riscv_multi_ctrl plus reset corner cases.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_multi_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        pc_we, adr_src, mem_we, ir_we, reg_we, retire, err;
  logic [1:0]  res_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_multi_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (instr[6:0]),
    .funct3    (instr[14:12]),
    .funct7b5  (instr[30]),
    .zero      (zero),
    .pc_we     (pc_we),
    .adr_src   (adr_src),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .res_src   (res_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .imm_src   (imm_src),
    .alu_ctrl  (alu_ctrl),
    .retire    (retire),
    .err       (err),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        err;
  } vec_t;

  vec_t vq[$];

  // {pc_we, adr_src, mem_we, ir_we, reg_we, res_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, retire}
  function automatic logic [16:0] cw(input logic pc, input logic adr, input logic mw,
                                     input logic ir, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic ret);
    return {pc, adr, mw, ir, rw, rs, a, b, imm, alu, ret};
  endfunction

  function automatic logic [16:0] fe(input logic [1:0] imm);
    return cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
  endfunction
  function automatic logic [16:0] de(input logic [1:0] imm);
    return cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
  endfunction
  function automatic logic [16:0] wb(input logic [1:0] imm);
    return cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1);
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic z, input logic [3:0] s,
                              input logic [16:0] c, input logic e);
    vec_t v;
    v.instr = i; v.zero = z; v.st = s; v.ctl = c; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction templates: whole-instruction per-cycle expectations.
  task automatic add_rtype(input logic [31:0] i, input logic [2:0] alu);
    vq.push_back(mk(i, 0, 4'd0, fe(2'b00), 0));
    vq.push_back(mk(i, 0, 4'd1, de(2'b00), 0));
    vq.push_back(mk(i, 0, 4'd6, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0), 0));
    vq.push_back(mk(i, 0, 4'd8, wb(2'b00), 0));
  endtask

  task automatic add_itype(input logic [31:0] i, input logic [2:0] alu);
    vq.push_back(mk(i, 0, 4'd0, fe(2'b00), 0));
    vq.push_back(mk(i, 0, 4'd1, de(2'b00), 0));
    vq.push_back(mk(i, 0, 4'd7, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0), 0));
    vq.push_back(mk(i, 0, 4'd8, wb(2'b00), 0));
  endtask

  task automatic add_beq(input logic [31:0] i, input logic z);
    vq.push_back(mk(i, z, 4'd0, fe(2'b10), 0));
    vq.push_back(mk(i, z, 4'd1, de(2'b10), 0));
    vq.push_back(mk(i, z, 4'd9, cw(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1), 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    instr = 32'h0;
    zero  = 1'b0;

    // sub x4,x4,x5 then lw, sw, two beq, I-type, other R-types, jal, illegal
    add_rtype(32'h40520233, 3'b001);
    vq.push_back(mk(32'hFFC4A303, 0, 4'd0, fe(2'b00), 0));
    vq.push_back(mk(32'hFFC4A303, 0, 4'd1, de(2'b00), 0));
    vq.push_back(mk(32'hFFC4A303, 0, 4'd2, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0), 0));
    vq.push_back(mk(32'hFFC4A303, 0, 4'd3, cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0), 0));
    vq.push_back(mk(32'hFFC4A303, 0, 4'd4, cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1), 0));
    vq.push_back(mk(32'h0064A423, 0, 4'd0, fe(2'b01), 0));
    vq.push_back(mk(32'h0064A423, 0, 4'd1, de(2'b01), 0));
    vq.push_back(mk(32'h0064A423, 0, 4'd2, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0), 0));
    vq.push_back(mk(32'h0064A423, 0, 4'd5, cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1), 0));
    add_beq(32'h00420463, 1'b1);
    add_beq(32'h00520463, 1'b0);
    add_itype(32'h00500093, 3'b000);
    add_itype(32'h40000093, 3'b000);
    add_rtype(32'h003160B3, 3'b011);
    add_rtype(32'h003170B3, 3'b010);
    add_rtype(32'h003120B3, 3'b101);
    vq.push_back(mk(32'h008000EF, 0, 4'd0, fe(2'b11), 0));
    vq.push_back(mk(32'h008000EF, 0, 4'd1, de(2'b11), 0));
    vq.push_back(mk(32'h008000EF, 0, 4'd10, cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0), 0));
    vq.push_back(mk(32'h008000EF, 0, 4'd8, wb(2'b11), 0));
    vq.push_back(mk(32'h00000000, 0, 4'd0, fe(2'b00), 0));
    vq.push_back(mk(32'h00000000, 0, 4'd1, de(2'b00), 0));
    vq.push_back(mk(32'h00000000, 0, 4'd15, 17'd0, 1));
    vq.push_back(mk(32'h00000000, 0, 4'd15, 17'd0, 1));
    vq.push_back(mk(32'h00000000, 0, 4'd15, 17'd0, 1));

    // Reset held: FETCH state but enables gated off.
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_enables", 32'({pc_we, ir_we, mem_we, reg_we, retire}), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      instr = vq[i].instr;
      zero  = vq[i].zero;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vq[i].st));
      chk($sformatf("vec%0d_ctl", i),
          32'({pc_we, adr_src, mem_we, ir_we, reg_we, res_src, alu_src_a, alu_src_b,
               imm_src, alu_ctrl, retire}), 32'(vq[i].ctl));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vq[i].err));
      @(negedge clk);
    end

    // Reset out of ERROR clears state and err immediately.
    rst = 1'b1;
    #1;
    chk("err_reset_state", 32'(state), 32'd0);
    chk("err_reset_err", 32'(err), 32'd0);
    chk("err_reset_gate", 32'({pc_we, ir_we}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unsupported funct3 in EXECR: no enables, then ERROR with err set.
    instr = 32'h00209033;
    #1;
    chk("f3_fetch", 32'(state), 32'd0);
    @(negedge clk); #1;
    chk("f3_decode", 32'(state), 32'd1);
    @(negedge clk); #1;
    chk("f3_execr", 32'(state), 32'd6);
    chk("f3_execr_en", 32'({pc_we, ir_we, mem_we, reg_we, retire}), 32'd0);
    chk("f3_execr_err", 32'(err), 32'd0);
    @(negedge clk); #1;
    chk("f3_error", 32'(state), 32'd15);
    chk("f3_err", 32'(err), 32'd1);
    chk("f3_error_en", 32'({pc_we, ir_we, mem_we, reg_we, retire}), 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Short reset pulse during MEMWRITE.
    instr = 32'h0064A423;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("sw_memwrite_state", 32'(state), 32'd5);
    chk("sw_memwrite_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #0.002;
    chk("pulse_mem_we", 32'(mem_we), 32'd0);
    chk("pulse_state", 32'(state), 32'd0);
    chk("pulse_retire", 32'(retire), 32'd0);
    rst = 1'b0;
    #0.5;
    chk("post_pulse_fetch", 32'(state), 32'd0);
    chk("post_pulse_ir_we", 32'(ir_we), 32'd1);
    @(negedge clk); #1;
    chk("post_pulse_decode", 32'(state), 32'd1);
    @(negedge clk); #1;
    chk("post_pulse_memadr", 32'(state), 32'd2);
    @(negedge clk); #1;
    chk("post_pulse_memwrite", 32'(state), 32'd5);
    chk("post_pulse_mem_we", 32'(mem_we), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
